// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use, branch-squash, multi-cycle EX and forwarding control for a 5-stage pipeline
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rt,
  input  logic       id_mc_op,
  input  logic       ex_mem_r,
  input  logic [4:0] ex_rs_addr,
  input  logic [4:0] ex_rt_addr,
  input  logic       branch_taken,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_dst_addr,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_dst_addr,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       id_ex_hold,
  output logic       ex_mem_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mc_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic       busy
);

  typedef enum logic {ST_RUN, ST_MC_WAIT} state_t;

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  if (MC_LAT < 2 || MC_LAT > 15 || CNT_W < 1) begin : g_bad_param
    $error("pipe_hazard_ctrl: MC_LAT must be 2..15 and CNT_W >= 1");
  end

  state_t     r_state, w_state_nxt;
  logic [3:0] r_mc_cnt, w_mc_cnt_nxt;
  logic       w_lu;

  assign w_lu = ex_mem_r && (ex_rt_addr != 5'd0) &&
                ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mc_cnt_nxt  = r_mc_cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_bubble = 1'b0;
    busy          = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      w_state_nxt   = ST_RUN;
      w_mc_cnt_nxt  = 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // Branch squash outranks both the stall and multi-cycle entry.
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_mc_op) begin
            w_state_nxt  = ST_MC_WAIT;
            w_mc_cnt_nxt = MC_LOAD;
          end
        end
        ST_MC_WAIT: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_hold    = 1'b1;
          ex_mem_bubble = 1'b1;
          busy          = 1'b1;
          if (r_mc_cnt <= 4'd1) begin
            w_state_nxt  = ST_RUN;
            w_mc_cnt_nxt = 4'd0;
          end else begin
            w_mc_cnt_nxt = r_mc_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt  = ST_RUN;
          w_mc_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // EX/MEM holds the newer value, so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_regwrite && mem_dst_addr != 5'd0 && mem_dst_addr == ex_rs_addr)
        fwd_a = 2'b10;
      else if (wb_regwrite && wb_dst_addr != 5'd0 && wb_dst_addr == ex_rs_addr)
        fwd_a = 2'b01;
      if (mem_regwrite && mem_dst_addr != 5'd0 && mem_dst_addr == ex_rt_addr)
        fwd_b = 2'b10;
      else if (wb_regwrite && wb_dst_addr != 5'd0 && wb_dst_addr == ex_rt_addr)
        fwd_b = 2'b01;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_lu_cnt, r_mc_cnt_perf, r_flush_cnt;
  logic             w_lu_ev, w_mc_ev, w_flush_ev;

  assign w_lu_ev    = (r_state == ST_RUN) && !branch_taken && w_lu;
  assign w_mc_ev    = (r_state == ST_MC_WAIT);
  assign w_flush_ev = (r_state == ST_RUN) && branch_taken;

  always_ff @(negedge clk) begin
    if (rst) begin
      r_lu_cnt      <= '0;
      r_mc_cnt_perf <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_lu_ev && r_lu_cnt != '1)         r_lu_cnt      <= r_lu_cnt + CNT_ONE;
      if (w_mc_ev && r_mc_cnt_perf != '1)    r_mc_cnt_perf <= r_mc_cnt_perf + CNT_ONE;
      if (w_flush_ev && r_flush_cnt != '1)   r_flush_cnt   <= r_flush_cnt + CNT_ONE;
    end
  end

  assign lu_stall_cnt = r_lu_cnt;
  assign mc_stall_cnt = r_mc_cnt_perf;
  assign flush_cnt    = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 16;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic [4:0] id_rs_addr = 0, id_rt_addr = 0, ex_rs_addr = 0, ex_rt_addr = 0;
  logic [4:0] mem_dst_addr = 0, wb_dst_addr = 0;
  logic       id_uses_rt = 0, id_mc_op = 0, ex_mem_r = 0, branch_taken = 0;
  logic       mem_regwrite = 0, wb_regwrite = 0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, busy;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] lu_stall_cnt, mc_stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] sb_q[$];
  string       tag_q[$];

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, fwd_a, fwd_b, busy}
  localparam logic [10:0] E_RUN = 11'b1_1_0_0_0_0_00_00_0;
  localparam logic [10:0] E_RST = 11'b0_0_1_1_0_1_00_00_0;
  localparam logic [10:0] E_LU  = 11'b0_0_0_1_0_0_00_00_0;
  localparam logic [10:0] E_BR  = 11'b1_1_1_1_0_0_00_00_0;
  localparam logic [10:0] E_MCW = 11'b0_0_0_0_1_1_00_00_1;

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt), .id_mc_op(id_mc_op),
    .ex_mem_r(ex_mem_r), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .branch_taken(branch_taken),
    .mem_regwrite(mem_regwrite), .mem_dst_addr(mem_dst_addr),
    .wb_regwrite(wb_regwrite), .wb_dst_addr(wb_dst_addr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef HAZ_PERF_CNT_EN
    .lu_stall_cnt(lu_stall_cnt), .mc_stall_cnt(mc_stall_cnt), .flush_cnt(flush_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; push the expectation, sample mid-cycle, then advance past the state edge.
  task automatic cycle(input string tag, input logic [10:0] exp);
    logic [10:0] e;
    string       t;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check(t, {21'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold,
              ex_mem_bubble, fwd_a, fwd_b, busy}, {21'd0, e});
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    cycle("reset_outputs", E_RST);
    rst = 1'b0;
    cycle("run_idle", E_RUN);

    ex_mem_r = 1; ex_rt_addr = 8; id_rs_addr = 8;
    cycle("lu_stall", E_LU);
    ex_mem_r = 0;
    cycle("lu_release", E_RUN);

    ex_mem_r = 1; ex_rt_addr = 0; id_rs_addr = 0;
    cycle("lu_r0_none", E_RUN);
    ex_rt_addr = 9; id_rt_addr = 9; id_uses_rt = 0;
    cycle("lu_rt_unused", E_RUN);
    id_uses_rt = 1;
    cycle("lu_rt_used", E_LU);
    ex_mem_r = 0; id_uses_rt = 0; id_rt_addr = 0; ex_rt_addr = 0;
    cycle("lu_rt_release", E_RUN);

    branch_taken = 1; ex_mem_r = 1; ex_rt_addr = 8; id_rs_addr = 8; id_mc_op = 1;
    cycle("branch_priority", E_BR);
    branch_taken = 0; ex_mem_r = 0; ex_rt_addr = 0; id_rs_addr = 0; id_mc_op = 0;
    cycle("branch_no_mc", E_RUN);

    id_mc_op = 1;
    cycle("mc1_entry", E_RUN);
    id_mc_op = 0;
    for (int i = 0; i < MC_LAT - 1; i++) cycle("mc1_wait", E_MCW);
    id_mc_op = 1;
    cycle("mc1_return_mc2_entry", E_RUN);
    id_mc_op = 1; branch_taken = 1; ex_mem_r = 1; ex_rt_addr = 3; id_rs_addr = 3;
    for (int i = 0; i < MC_LAT - 1; i++) cycle("mc2_wait_ignores", E_MCW);
    id_mc_op = 0; branch_taken = 0; ex_mem_r = 0; ex_rt_addr = 0; id_rs_addr = 0;
    cycle("mc2_return", E_RUN);
    cycle("mc2_after", E_RUN);

    mem_regwrite = 1; mem_dst_addr = 5; wb_regwrite = 1; wb_dst_addr = 5; ex_rs_addr = 5;
    cycle("fwd_a_mem_wins", E_RUN | 11'b000_000_10_00_0);
    mem_regwrite = 0;
    cycle("fwd_a_wb", E_RUN | 11'b000_000_01_00_0);
    ex_rs_addr = 0; ex_rt_addr = 5;
    cycle("fwd_b_wb", E_RUN | 11'b000_000_00_01_0);
    mem_regwrite = 1; mem_dst_addr = 7; ex_rt_addr = 7;
    cycle("fwd_b_mem", E_RUN | 11'b000_000_00_10_0);
    mem_dst_addr = 0; wb_dst_addr = 0; ex_rs_addr = 0; ex_rt_addr = 0;
    cycle("fwd_r0_none", E_RUN);
    mem_regwrite = 0; wb_regwrite = 0;

`ifdef HAZ_PERF_CNT_EN
    check("cnt_lu", {16'd0, lu_stall_cnt}, 32'd2);
    check("cnt_mc", {16'd0, mc_stall_cnt}, 32'(2 * (MC_LAT - 1)));
    check("cnt_flush", {16'd0, flush_cnt}, 32'd1);
`endif

    id_mc_op = 1;
    cycle("mc3_entry", E_RUN);
    id_mc_op = 0;
    cycle("mc3_wait1", E_MCW);
    cycle("mc3_wait2", E_MCW);
    rst = 1; mem_regwrite = 1; mem_dst_addr = 4; ex_rs_addr = 4;
    cycle("mc3_reset", E_RST);
    rst = 0; mem_regwrite = 0; mem_dst_addr = 0; ex_rs_addr = 0;
    cycle("post_reset_run", E_RUN);
    cycle("post_reset_run2", E_RUN);

`ifdef HAZ_PERF_CNT_EN
    check("cnt_lu_clr", {16'd0, lu_stall_cnt}, 32'd0);
    check("cnt_mc_clr", {16'd0, mc_stall_cnt}, 32'd0);
    check("cnt_flush_clr", {16'd0, flush_cnt}, 32'd0);
`endif

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
